// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async FIFO write and read sides.
// Gray conversions work on zero-extended values, so one pair of functions
// serves every pointer width; callers cast to and from PTR_MAX_W.
package fifo_ptr_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int PTR_MAX_W  = 32;

  // Binary to reflected Gray; upper zero bits stay zero.
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary as a prefix XOR from the MSB down (log-depth fold).
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = g;
    for (int s = 1; s < PTR_MAX_W; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/bin2gray_n.sv
// Combinational N-bit binary to Gray encoder.
module bin2gray_n
  import fifo_ptr_pkg::*;
#(
  parameter int N = 5
) (
  input  logic [N-1:0] bin_i,
  output logic [N-1:0] gray_o
);

  logic [PTR_MAX_W-1:0] gray_w;

  // Widen, encode, narrow back; the dropped upper bits are always zero.
  always_comb begin
    gray_w = bin2gray(PTR_MAX_W'(bin_i));
    gray_o = gray_w[N-1:0];
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-side pointer and full-flag generator.
// Keeps a binary write pointer, exports its registered Gray image, brings the
// read Gray pointer in through a two-flop synchroniser and registers wfull.
// Optional almost-full flag: define FIFO_WPTR_AF_EN to add walmost_full.
module fifo_wptr_full
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int AF_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              winc,
  input  logic [ADDR_W:0]   rgray_async,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wgray,
  output logic              wfull
`ifdef FIFO_WPTR_AF_EN
  ,
  output logic              walmost_full
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Reject configurations the pointer compare cannot handle.
  if (ADDR_W < 2 || AF_MARGIN < 0 || AF_MARGIN > DEPTH) begin : g_cfg_chk
    $error("fifo_wptr_full: illegal ADDR_W/AF_MARGIN");
  end

  logic [ADDR_W:0] wbin_q, wbin_d;
  logic [ADDR_W:0] wgray_q, wgray_d;
  logic [ADDR_W:0] rq1_q, rq2_q;
  logic            wfull_q, wfull_d;
  logic            wacc;

  // Writes while full are dropped; the pointer only moves on accepted ones.
  always_comb begin
    wacc   = winc & ~wfull_q;
    wbin_d = wbin_q + {{ADDR_W{1'b0}}, wacc};
  end

  bin2gray_n #(.N(ADDR_W + 1)) u_b2g (
    .bin_i  (wbin_d),
    .gray_o (wgray_d)
  );

  // Full when the next write pointer is one lap ahead of the synced read
  // pointer: in Gray that means the top two bits inverted, the rest equal.
  // Using the stale rq2 makes the flag conservative, never optimistic.
  always_comb begin
    wfull_d = (wgray_d == {~rq2_q[ADDR_W:ADDR_W-1], rq2_q[ADDR_W-2:0]});
  end

  // Pointer, Gray image, synchroniser and full flag state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      wfull_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rgray_async;
      rq2_q   <= rq1_q;
      wfull_q <= wfull_d;
    end
  end

  assign waddr = wbin_q[ADDR_W-1:0];
  assign wgray = wgray_q;
  assign wfull = wfull_q;

`ifdef FIFO_WPTR_AF_EN
  localparam logic [ADDR_W:0] AF_THR = (ADDR_W + 1)'(DEPTH - AF_MARGIN);

  logic [ADDR_W:0] rbin_s;
  logic [ADDR_W:0] level_nxt;
  logic            waf_q, waf_d;

  // Occupancy after this cycle's write, against the synced read pointer.
  // A full FIFO has level DEPTH, so the flag is high whenever wfull is.
  always_comb begin
    rbin_s    = (ADDR_W + 1)'(gray2bin(PTR_MAX_W'(rq2_q)));
    level_nxt = wbin_d - rbin_s;
    waf_d     = (level_nxt >= AF_THR);
  end

  // Registered almost-full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) waf_q <= 1'b0;
    else        waf_q <= waf_d;
  end

  assign walmost_full = waf_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full at ADDR_W=2 (DEPTH=4).
// Each step drives inputs on the falling edge, queues the expected outputs
// and checks them 1ns after the next rising edge.
module tb_fifo_wptr_full;

  typedef struct packed {
    logic [1:0] waddr;
    logic [2:0] wgray;
    logic       wfull;
    logic       af;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       winc;
  logic [2:0] rgray_async;
  logic [1:0] waddr;
  logic [2:0] wgray;
  logic       wfull;
`ifdef FIFO_WPTR_AF_EN
  logic       walmost_full;
`endif

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];
  logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                           3'b110, 3'b111, 3'b101, 3'b100};

  fifo_wptr_full #(.ADDR_W(2), .AF_MARGIN(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .rgray_async  (rgray_async),
    .waddr        (waddr),
    .wgray        (wgray),
    .wfull        (wfull)
`ifdef FIFO_WPTR_AF_EN
    ,
    .walmost_full (walmost_full)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [1:0] a, input logic [2:0] g,
                              input logic f, input logic af);
    exp_t e;
    e.waddr = a; e.wgray = g; e.wfull = f; e.af = af;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".waddr"}, {6'd0, waddr}, {6'd0, e.waddr});
      chk({tag, ".wgray"}, {5'd0, wgray}, {5'd0, e.wgray});
      chk({tag, ".wfull"}, {7'd0, wfull}, {7'd0, e.wfull});
`ifdef FIFO_WPTR_AF_EN
      chk({tag, ".walmost_full"}, {7'd0, walmost_full}, {7'd0, e.af});
`endif
    end
  endtask

  task automatic step(input string tag, input logic w, input logic [2:0] rg, input exp_t e);
    @(negedge clk);
    winc        = w;
    rgray_async = rg;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic chk_now(input string tag, input exp_t e);
    sb.push_back(e);
    check_out(tag);
  endtask

  initial begin
    rst_n = 1'b0; winc = 1'b0; rgray_async = 3'b000;
    #3;
    chk_now("reset", mk(2'd0, 3'b000, 1'b0, 1'b0));
    @(negedge clk); rst_n = 1'b1;

    // Idle after reset.
    step("idle0", 1'b0, 3'b000, mk(2'd0, 3'b000, 1'b0, 1'b0));
    step("idle1", 1'b0, 3'b000, mk(2'd0, 3'b000, 1'b0, 1'b0));

    // Fill to full with the read pointer parked at zero.
    step("fill1", 1'b1, 3'b000, mk(2'd1, 3'b001, 1'b0, 1'b0));
    step("fill2", 1'b1, 3'b000, mk(2'd2, 3'b011, 1'b0, 1'b1));
    step("fill3", 1'b1, 3'b000, mk(2'd3, 3'b010, 1'b0, 1'b1));
    step("fill4", 1'b1, 3'b000, mk(2'd0, 3'b110, 1'b1, 1'b1));

    // Writes while full are dropped.
    for (int i = 0; i < 5; i++)
      step($sformatf("hold%0d", i), 1'b1, 3'b000, mk(2'd0, 3'b110, 1'b1, 1'b1));

    // One read: wfull drops only after the third edge.
    step("rel1", 1'b0, 3'b001, mk(2'd0, 3'b110, 1'b1, 1'b1));
    step("rel2", 1'b0, 3'b001, mk(2'd0, 3'b110, 1'b1, 1'b1));
    step("rel3", 1'b0, 3'b001, mk(2'd0, 3'b110, 1'b0, 1'b1));

    // Refill the freed slot.
    step("refill", 1'b1, 3'b001, mk(2'd1, 3'b111, 1'b1, 1'b1));
    step("refill_idle", 1'b0, 3'b001, mk(2'd1, 3'b111, 1'b1, 1'b1));

    // Clean reset, then three writes to reach wgray=010.
    @(negedge clk); rst_n = 1'b0; winc = 1'b0; rgray_async = 3'b000;
    @(negedge clk); rst_n = 1'b1;
    step("pre1", 1'b1, 3'b000, mk(2'd1, 3'b001, 1'b0, 1'b0));
    step("pre2", 1'b1, 3'b000, mk(2'd2, 3'b011, 1'b0, 1'b1));
    step("pre3", 1'b1, 3'b000, mk(2'd3, 3'b010, 1'b0, 1'b1));

    // Asynchronous reset away from any clock edge.
    #2;
    rst_n = 1'b0; winc = 1'b0;
    #1;
    chk_now("async_rst", mk(2'd0, 3'b000, 1'b0, 1'b0));
    @(negedge clk); rst_n = 1'b1;

    // Eight writes with the read pointer following; pointer wraps to zero.
    for (int k = 1; k <= 8; k++)
      step($sformatf("wrap%0d", k), 1'b1, gtab[k % 8],
           mk(2'(k % 4), gtab[k % 8], 1'b0, (k == 1) ? 1'b0 : 1'b1));

    chk("sb_drained", 8'(sb.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
